// File: rtl/requant_wb_packer.sv
// requant_wb_packer
//   Packs PACK consecutive LANES x OUT_BITS requantizer vectors into one
//   memory word, queues the words (with address and slot mask) in a small
//   first-word-fall-through FIFO and drives a valid/ready write port toward
//   the activation SRAM. The upstream has no backpressure: a word that finds
//   the FIFO full is dropped and the sticky overflow flag is raised.
//
// Ports
//   CLK, RESET      clock, asynchronous active-high reset
//   start           begin a tile (accepted in IDLE only), latches cfg_*
//   cfg_base_addr   first word address of the tile
//   cfg_num_vec     number of input vectors in the tile (0 = empty tile)
//   in_q, in_valid  requantized vector and its valid strobe
//   wr_valid/ready  write handshake toward the SRAM
//   wr_addr         word address of the head FIFO entry
//   wr_data         packed word, slot 0 in the LSBs
//   wr_mask         per-slot write enable
//   busy            high while RUN or FLUSH
//   done            one-cycle tile-complete pulse
//   overflow        sticky: at least one packed word was dropped
module requant_wb_packer #(
    parameter int LANES      = 16,
    parameter int OUT_BITS   = 8,
    parameter int PACK       = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_BITS  = 16
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            start,
    input  logic [ADDR_BITS-1:0]            cfg_base_addr,
    input  logic [15:0]                     cfg_num_vec,
    input  logic [LANES*OUT_BITS-1:0]       in_q,
    input  logic                            in_valid,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [ADDR_BITS-1:0]            wr_addr,
    output logic [PACK*LANES*OUT_BITS-1:0]  wr_data,
    output logic [PACK-1:0]                 wr_mask,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);

    localparam int VW     = LANES * OUT_BITS;
    localparam int WW     = PACK * VW;
    localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
    state_t state_q, state_d;

    logic [15:0]           num_vec_q;
    logic [15:0]           vec_cnt_q;
    logic [SLOT_W-1:0]     slot_cnt_q;
    logic [WW-1:0]         slots_q;
    logic [ADDR_BITS-1:0]  addr_q;

    logic [WW-1:0]         fifo_data [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  fifo_addr [FIFO_DEPTH];
    logic [PACK-1:0]       fifo_mask [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  start_ok;
    logic                  accept;
    logic                  last_vec;
    logic                  slot_last;
    logic                  word_done;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic [WW-1:0]         push_data;
    logic [PACK-1:0]       push_mask;

    assign start_ok   = start && (state_q == S_IDLE);
    assign accept     = in_valid && (state_q == S_RUN);
    assign last_vec   = (vec_cnt_q == num_vec_q - 16'd1);
    assign slot_last  = (slot_cnt_q == SLOT_W'(PACK - 1));
    assign word_done  = accept && (slot_last || last_vec);
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && wr_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push       = word_done && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);

    // Current slot buffer with the incoming vector merged into its slot;
    // mask covers every slot up to and including the current one.
    always_comb begin
        push_data = slots_q;
        push_mask = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (SLOT_W'(i) == slot_cnt_q) begin
                push_data[i*VW +: VW] = in_q;
            end
            if (SLOT_W'(i) <= slot_cnt_q) begin
                push_mask[i] = 1'b1;
            end
        end
    end

    // FSM
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cfg_num_vec == 16'd0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (accept && last_vec) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packing counters and slot buffer. The address advances on every
    // completed word, dropped or not, so later words keep their addresses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            num_vec_q  <= '0;
            vec_cnt_q  <= '0;
            slot_cnt_q <= '0;
            slots_q    <= '0;
            addr_q     <= '0;
            overflow   <= 1'b0;
        end else if (start_ok) begin
            num_vec_q  <= cfg_num_vec;
            vec_cnt_q  <= '0;
            slot_cnt_q <= '0;
            slots_q    <= '0;
            addr_q     <= cfg_base_addr;
            overflow   <= 1'b0;
        end else if (accept) begin
            vec_cnt_q <= vec_cnt_q + 16'd1;
            if (word_done) begin
                slot_cnt_q <= '0;
                slots_q    <= '0;
                addr_q     <= addr_q + ADDR_BITS'(1);
                if (!push) begin
                    overflow <= 1'b1;
                end
            end else begin
                slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
                slots_q    <= push_data;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // FIFO storage (no reset; outputs are gated while empty)
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= push_data;
            fifo_addr[wr_ptr_q] <= addr_q;
            fifo_mask[wr_ptr_q] <= push_mask;
        end
    end

    assign wr_valid = !fifo_empty;
    assign wr_addr  = fifo_empty ? '0 : fifo_addr[rd_ptr_q];
    assign wr_data  = fifo_empty ? '0 : fifo_data[rd_ptr_q];
    assign wr_mask  = fifo_empty ? '0 : fifo_mask[rd_ptr_q];

endmodule

// File: tb/tb_requant_wb_packer.sv
`timescale 1ns/1ps
// Directed bench for requant_wb_packer with a scoreboard of expected writes.
module tb_requant_wb_packer;

    localparam int LANES      = 16;
    localparam int OUT_BITS   = 8;
    localparam int PACK       = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_BITS  = 16;
    localparam int VW         = LANES * OUT_BITS;
    localparam int WW         = PACK * VW;

    logic                  CLK = 1'b0;
    logic                  RESET = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_BITS-1:0]  cfg_base_addr = '0;
    logic [15:0]           cfg_num_vec = '0;
    logic [VW-1:0]         in_q = '0;
    logic                  in_valid = 1'b0;
    logic                  wr_valid;
    logic                  wr_ready = 1'b0;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [WW-1:0]         wr_data;
    logic [PACK-1:0]       wr_mask;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    requant_wb_packer #(
        .LANES(LANES),
        .OUT_BITS(OUT_BITS),
        .PACK(PACK),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .start(start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_vec(cfg_num_vec),
        .in_q(in_q),
        .in_valid(in_valid),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [WW-1:0]        data;
        logic [PACK-1:0]      mask;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    int  hs_cnt = 0;
    int  occ;
    bit  pushed_now = 1'b0;
    logic exp_ovf = 1'b0;

    // reference packer state
    logic [ADDR_BITS-1:0] m_addr;
    logic [WW-1:0]        m_word;
    int                   m_slot;
    int                   m_vec;
    int                   m_num;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [VW-1:0] rv();
        logic [VW-1:0] r;
        for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic begin_tile(input logic [ADDR_BITS-1:0] base, input int num);
        start         = 1'b1;
        cfg_base_addr = base;
        cfg_num_vec   = 16'(num);
        m_addr  = base;
        m_word  = '0;
        m_slot  = 0;
        m_vec   = 0;
        m_num   = num;
        exp_ovf = 1'b0;
        step();
        start = 1'b0;
    endtask

    // Drives one vector this cycle; the completed word is predicted against
    // the FIFO occupancy seen this cycle and the wr_ready being driven now.
    task automatic send_vec(input logic [VW-1:0] v);
        in_q     = v;
        in_valid = 1'b1;
        m_word[m_slot*VW +: VW] = v;
        m_slot++;
        m_vec++;
        if (m_slot == PACK || m_vec == m_num) begin
            wr_t w;
            w.addr = m_addr;
            w.data = m_word;
            w.mask = PACK'((1 << m_slot) - 1);
            if (exp_q.size() < FIFO_DEPTH || (exp_q.size() > 0 && wr_ready)) begin
                exp_q.push_back(w);
                pushed_now = 1'b1;
            end else begin
                exp_ovf = 1'b1;
            end
            m_addr = m_addr + 1'b1;
            m_slot = 0;
            m_word = '0;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int c0;
        int k;
        c0 = done_cnt;
        k  = 0;
        while (done_cnt == c0 && k < budget) begin
            if (toggle) wr_ready = ~wr_ready;
            step();
            k++;
        end
        chk("done_seen", done_cnt != c0, 1);
        repeat (3) step();
        chk("done_once", done_cnt - c0, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("overflow_end", overflow, exp_ovf);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_wr_mask"}, wr_mask, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // Write-port monitor: head of the scoreboard must be presented whenever
    // the FIFO is expected to be non-empty, and is retired on a handshake.
    always @(negedge CLK) begin
        if (!RESET) begin
            occ = exp_q.size() - (pushed_now ? 1 : 0);
            chk("wr_valid", wr_valid, occ > 0);
            if (occ > 0 && wr_valid) begin
                chk("wr_addr", wr_addr, exp_q[0].addr);
                chk("wr_data", wr_data, exp_q[0].data);
                chk("wr_mask", wr_mask, exp_q[0].mask);
                if (wr_ready) begin
                    exp_q.delete(0);
                    hs_cnt++;
                end
            end
            if (done) done_cnt++;
        end
        pushed_now = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int c0;

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk_zero_outputs("reset");
        RESET = 1'b0;
        step();

        // 1: basic tile, one vector per cycle
        wr_ready = 1'b1;
        h0 = hs_cnt;
        begin_tile(16'h0100, 4);
        chk("t1_busy", busy, 1);
        send_vec(rv());
        chk("t1_no_valid_after_v0", wr_valid, 0);
        send_vec(rv());
        chk("t1_valid_after_v1", wr_valid, 1);
        send_vec(rv());
        send_vec(rv());
        wait_done(50, 1'b0);
        chk("t1_writes", hs_cnt - h0, 2);

        // 2: odd count, partial final word
        h0 = hs_cnt;
        begin_tile(16'h0010, 3);
        for (int i = 0; i < 3; i++) send_vec(rv());
        wait_done(50, 1'b0);
        chk("t2_writes", hs_cnt - h0, 2);

        // 3: backpressure and overflow
        wr_ready = 1'b0;
        h0 = hs_cnt;
        begin_tile(16'h0400, 32);
        for (int i = 0; i < 32; i++) send_vec(rv());
        step();
        chk("t3_overflow_set", overflow, 1);
        c0 = done_cnt;
        repeat (5) step();
        chk("t3_no_done_while_stalled", done_cnt - c0, 0);
        chk("t3_busy_stalled", busy, 1);
        wr_ready = 1'b1;
        wait_done(100, 1'b0);
        chk("t3_writes", hs_cnt - h0, 8);

        // 4: address wrap with toggling wr_ready
        h0 = hs_cnt;
        wr_ready = 1'b0;
        begin_tile(16'hFFFF, 4);
        chk("t4_overflow_cleared", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            wr_ready = ~wr_ready;
            send_vec(rv());
        end
        wait_done(100, 1'b1);
        chk("t4_writes", hs_cnt - h0, 2);

        // 5a: empty tile, done two cycles after start
        wr_ready = 1'b1;
        h0 = hs_cnt;
        begin_tile(16'h0777, 0);
        chk("t5_empty_busy_t1", busy, 1);
        chk("t5_empty_done_t1", done, 0);
        step();
        chk("t5_empty_done_t2", done, 1);
        chk("t5_empty_busy_t2", busy, 0);
        step();
        chk("t5_empty_done_t3", done, 0);
        chk("t5_empty_writes", hs_cnt - h0, 0);

        // 5b: start during RUN is ignored
        h0 = hs_cnt;
        begin_tile(16'h0050, 2);
        send_vec(rv());
        start         = 1'b1;
        cfg_base_addr = 16'h0999;
        cfg_num_vec   = 16'd0;
        step();
        start = 1'b0;
        send_vec(rv());
        wait_done(50, 1'b0);
        chk("t5_restart_writes", hs_cnt - h0, 1);

        // 5c: in_valid in IDLE is ignored
        h0 = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            in_q     = rv();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("t5_idle_valid", wr_valid, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_writes", hs_cnt - h0, 0);

        // 6: reset mid-tile, then a clean tile
        wr_ready = 1'b0;
        begin_tile(16'h0200, 8);
        for (int i = 0; i < 3; i++) send_vec(rv());
        c0 = done_cnt;
        #2;
        RESET = 1'b1;
        #1;
        chk_zero_outputs("t6_reset");
        exp_q.delete();
        pushed_now = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        step();
        chk("t6_no_done", done_cnt - c0, 0);
        chk("t6_idle_valid", wr_valid, 0);
        wr_ready = 1'b1;
        h0 = hs_cnt;
        begin_tile(16'h0300, 2);
        send_vec(rv());
        send_vec(rv());
        wait_done(50, 1'b0);
        chk("t6_writes", hs_cnt - h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
